// File: rtl/ps2_key_decoder_pkg.sv
// +----------------------------------------------------------------------------+
// | ps2_pkg                                                                    |
// | Shared constants, state encoding and key lookup for the PS/2 key decoder.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BRK       = 8'hF0;
  localparam int         PS2_FRAME_LEN = 11;

  localparam logic [7:0] DEF_KEY_UP    = 8'h1D;
  localparam logic [7:0] DEF_KEY_RIGHT = 8'h23;
  localparam logic [7:0] DEF_KEY_DOWN  = 8'h1B;
  localparam logic [7:0] DEF_KEY_LEFT  = 8'h1C;

  localparam int DIR_UP    = 3;
  localparam int DIR_RIGHT = 2;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 0;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_t;

  // One-hot direction for a scan code, or zero when the code is unmapped.
  function automatic logic [3:0] key_onehot(input logic [7:0] code,
                                            input logic [7:0] up,
                                            input logic [7:0] right,
                                            input logic [7:0] down,
                                            input logic [7:0] left);
    logic [3:0] oh;
    oh = 4'b0000;
    if (code == up)    oh[DIR_UP]    = 1'b1;
    if (code == right) oh[DIR_RIGHT] = 1'b1;
    if (code == down)  oh[DIR_DOWN]  = 1'b1;
    if (code == left)  oh[DIR_LEFT]  = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_decoder_if.sv
// +----------------------------------------------------------------------------+
// | ps2_key_decoder_if                                                         |
// | Key event bus from the PS/2 decoder to the game/control logic.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ps2_key_decoder_if;
  logic [3:0] o_direccion;
  logic       o_key_valid;
  logic [7:0] o_scancode;
  logic       o_extended;
  logic       o_break;
  logic       o_frame_err;

  modport master (
    output o_direccion, o_key_valid, o_scancode, o_extended, o_break, o_frame_err
  );

  modport slave (
    input o_direccion, o_key_valid, o_scancode, o_extended, o_break, o_frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_decoder_rx_frame.sv
// +----------------------------------------------------------------------------+
// | ps2_rx_frame                                                               |
// | Synchronises and filters the PS/2 lines, assembles and checks 11-bit frames|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 1000
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  input  wire logic       ps2_clk_i,
  input  wire logic       ps2_data_i,
  output logic [7:0]      byte_o,
  output logic            byte_valid_o,
  output logic            frame_err_o
);

  localparam int unsigned TO_CYC   = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam logic [31:0] TO_LAST  = 32'(TO_CYC - 1);
  localparam logic [4:0]  FILT_MAX = 5'(FILTER_LEN - 1);
  localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_LEN - 1);

  logic [1:0]  clk_sync_q, dat_sync_q;
  logic        filt_q, strobe_q, dat_q;
  logic [4:0]  filt_cnt_q;
  rx_state_t   state_q;
  logic [3:0]  bitcnt_q;
  logic [10:0] frame_q;
  logic [31:0] to_cnt_q;
  logic        timeout_hit, frame_ok;

  // The filter only accepts a new level after FILTER_LEN matching samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b00;
      dat_sync_q <= 2'b00;
      filt_q     <= 1'b0;
      filt_cnt_q <= 5'd0;
      strobe_q   <= 1'b0;
      dat_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      strobe_q   <= 1'b0;
      if (clk_sync_q[1] != filt_q) begin
        if (filt_cnt_q == FILT_MAX) begin
          filt_q     <= clk_sync_q[1];
          filt_cnt_q <= 5'd0;
          strobe_q   <= ~clk_sync_q[1];
          dat_q      <= dat_sync_q[1];
        end else begin
          filt_cnt_q <= filt_cnt_q + 5'd1;
        end
      end else begin
        filt_cnt_q <= 5'd0;
      end
    end
  end

  assign timeout_hit = (state_q == RX_SHIFT) && !strobe_q && (to_cnt_q == TO_LAST);
  assign frame_ok    = !frame_q[0] && frame_q[10] && (^frame_q[9:1]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RX_IDLE;
      bitcnt_q <= 4'd0;
      frame_q  <= 11'd0;
      to_cnt_q <= 32'd0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          to_cnt_q <= 32'd0;
          if (strobe_q && !dat_q) begin
            frame_q  <= {1'b0, frame_q[10:1]};
            bitcnt_q <= 4'd1;
            state_q  <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (strobe_q) begin
            frame_q  <= {dat_q, frame_q[10:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            to_cnt_q <= 32'd0;
            if (bitcnt_q == LAST_BIT) state_q <= RX_CHECK;
          end else if (timeout_hit) begin
            state_q  <= RX_IDLE;
            bitcnt_q <= 4'd0;
            to_cnt_q <= 32'd0;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        RX_CHECK: begin
          state_q  <= RX_IDLE;
          bitcnt_q <= 4'd0;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_o       = frame_q[8:1];
  assign byte_valid_o = (state_q == RX_CHECK) && frame_ok;
  assign frame_err_o  = ((state_q == RX_CHECK) && !frame_ok) || timeout_hit;

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// +----------------------------------------------------------------------------+
// | ps2_key_decoder                                                            |
// | PS/2 keyboard front end: E0/F0 prefix tracking and held-direction state.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int         CLK_HZ     = 50000000,
  parameter int         FILTER_LEN = 8,
  parameter int         TIMEOUT_US = 1000,
  parameter int         HOLD_MODE  = 1,
  parameter logic [7:0] KEY_UP     = DEF_KEY_UP,
  parameter logic [7:0] KEY_RIGHT  = DEF_KEY_RIGHT,
  parameter logic [7:0] KEY_DOWN   = DEF_KEY_DOWN,
  parameter logic [7:0] KEY_LEFT   = DEF_KEY_LEFT
) (
  input  wire logic           Clock,
  input  wire logic           Reset,
  input  wire logic           iPS2CLK,
  input  wire logic           iPS2D,
  ps2_key_decoder_if.master   key_o
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;
  logic       ext_q, brk_q;
  logic [3:0] dir_q, dir_d, key_hit;
  logic [7:0] scancode_q;
  logic       extended_q, break_q, key_valid_q, frame_err_q;

  ps2_rx_frame #(
    .CLK_HZ     (CLK_HZ),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_US (TIMEOUT_US)
  ) u_rx (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .ps2_clk_i    (iPS2CLK),
    .ps2_data_i   (iPS2D),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  assign key_hit = key_onehot(rx_byte, KEY_UP, KEY_RIGHT, KEY_DOWN, KEY_LEFT);

  always_comb begin
    dir_d = dir_q;
    if (HOLD_MODE != 0) begin
      dir_d = brk_q ? (dir_q & ~key_hit) : (dir_q | key_hit);
    end else if (!brk_q) begin
      dir_d = key_hit;
    end else if (dir_q == key_hit) begin
      // A release of a key other than the latched one leaves it latched.
      dir_d = 4'b0000;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      dir_q       <= 4'b0000;
      scancode_q  <= 8'd0;
      extended_q  <= 1'b0;
      break_q     <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_err) begin
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        brk_q       <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == PS2_EXT) begin
          ext_q <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk_q <= 1'b1;
        end else begin
          scancode_q  <= rx_byte;
          extended_q  <= ext_q;
          break_q     <= brk_q;
          key_valid_q <= 1'b1;
          ext_q       <= 1'b0;
          brk_q       <= 1'b0;
          if (!ext_q && (key_hit != 4'b0000)) dir_q <= dir_d;
        end
      end
    end
  end

  assign key_o.o_direccion = dir_q;
  assign key_o.o_key_valid = key_valid_q;
  assign key_o.o_scancode  = scancode_q;
  assign key_o.o_extended  = extended_q;
  assign key_o.o_break     = break_q;
  assign key_o.o_frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// +----------------------------------------------------------------------------+
// | tb_ps2_key_decoder                                                         |
// | Byte-level reference model plus directed PS/2 frames for ps2_key_decoder.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ps2_key_decoder;

  localparam int HALF = 20;   // PS/2 half period in system clocks
  localparam int GAP  = 30;
  // Raw falling edge -> key_valid seen at the 12th following negedge:
  // 2 sync flops + 8 filter samples + shift + decoder register.
  localparam int LAT  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;
  int   cyc = 0;
  int   fall_cyc = 0;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] dir;
  } ev_t;

  ev_t        exp_q[$];
  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic [3:0] m_dir = 4'b0000;
  int         vectors = 0, miscompares = 0;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .CLK_HZ(1000000), .FILTER_LEN(8), .TIMEOUT_US(200), .HOLD_MODE(1),
    .KEY_UP(8'h1D), .KEY_RIGHT(8'h23), .KEY_DOWN(8'h1B), .KEY_LEFT(8'h1C)
  ) dut (
    .Clock(clk), .Reset(rst), .iPS2CLK(ps2c), .iPS2D(ps2d), .key_o(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] key_bit(input logic [7:0] c);
    case (c)
      8'h1C:   return 4'b0001;
      8'h1B:   return 4'b0010;
      8'h23:   return 4'b0100;
      8'h1D:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [3:0] kb;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      kb = key_bit(b);
      if (!m_ext && kb != 4'b0000) m_dir = m_brk ? (m_dir & ~kb) : (m_dir | kb);
      exp_q.push_back('{1'b0, b, m_ext, m_brk, m_dir});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_err();
    m_ext = 1'b0;
    m_brk = 1'b0;
    exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0, m_dir});
  endtask

  task automatic drive(input logic [7:0] b, input bit flip_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      repeat (HALF) @(negedge clk);
      if (i == 10) fall_cyc = cyc;
      ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    drive(b, 1'b0, 11);
    ps2d = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  // Compare process: strobes pop the model queue, quiet cycles check held state.
  initial begin
    ev_t        e;
    logic [3:0] h_dir;
    logic [7:0] h_code;
    logic       h_ext, h_brk;
    h_dir = 4'b0; h_code = 8'h0; h_ext = 1'b0; h_brk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        h_dir = 4'b0; h_code = 8'h0; h_ext = 1'b0; h_brk = 1'b0;
      end else if (bus.o_key_valid || bus.o_frame_err) begin
        check("strobes_exclusive", {31'd0, bus.o_key_valid & bus.o_frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, bus.o_key_valid, bus.o_frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {31'd0, bus.o_frame_err}, {31'd0, e.err});
          if (!e.err) begin
            check("ev_scancode", {24'd0, bus.o_scancode}, {24'd0, e.code});
            check("ev_extended", {31'd0, bus.o_extended}, {31'd0, e.ext});
            check("ev_break", {31'd0, bus.o_break}, {31'd0, e.brk});
            check("ev_latency", cyc - fall_cyc, LAT);
            h_code = e.code; h_ext = e.ext; h_brk = e.brk;
          end
          check("ev_direccion", {28'd0, bus.o_direccion}, {28'd0, e.dir});
          h_dir = e.dir;
        end
      end else begin
        check("held_direccion", {28'd0, bus.o_direccion}, {28'd0, h_dir});
        check("held_scancode", {24'd0, bus.o_scancode}, {24'd0, h_code});
        check("held_flags", {30'd0, bus.o_extended, bus.o_break}, {30'd0, h_ext, h_brk});
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_direccion", {28'd0, bus.o_direccion}, 32'd0);
    check("rst_scancode", {24'd0, bus.o_scancode}, 32'd0);
    check("rst_strobes", {30'd0, bus.o_key_valid, bus.o_frame_err}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    send(8'h1C);
    check("t1_dir", {28'd0, bus.o_direccion}, 32'h1);
    check("t1_code", {24'd0, bus.o_scancode}, 32'h1C);
    check("t1_brk", {31'd0, bus.o_break}, 32'd0);
    send(8'hF0); send(8'h1C);
    check("t1_release", {28'd0, bus.o_direccion}, 32'h0);

    send(8'h1D);
    check("t2_up", {28'd0, bus.o_direccion}, 32'h8);
    send(8'h23);
    check("t2_up_right", {28'd0, bus.o_direccion}, 32'hC);
    send(8'hF0); send(8'h1D);
    check("t2_right", {28'd0, bus.o_direccion}, 32'h4);
    check("t2_brk", {31'd0, bus.o_break}, 32'd1);
    check("t2_code", {24'd0, bus.o_scancode}, 32'h1D);
    send(8'hF0); send(8'h23);

    send(8'hE0); send(8'h75);
    check("t3_ext_make", {30'd0, bus.o_extended, bus.o_break}, 32'b10);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t3_ext_break", {30'd0, bus.o_extended, bus.o_break}, 32'b11);
    check("t3_dir", {28'd0, bus.o_direccion}, 32'h0);

    model_err();
    drive(8'h1B, 1'b1, 11);
    ps2d = 1'b1;
    repeat (GAP) @(negedge clk);
    check("t4_dir_after_err", {28'd0, bus.o_direccion}, 32'h0);
    send(8'h1B);
    check("t4_down", {28'd0, bus.o_direccion}, 32'h2);
    send(8'h1B);
    check("t4_typematic", {28'd0, bus.o_direccion}, 32'h2);

    model_err();
    drive(8'h23, 1'b0, 5);
    ps2d = 1'b1;
    repeat (400) @(negedge clk);
    send(8'h23);
    check("t5_right", {28'd0, bus.o_direccion}, 32'h6);
    check("t5_code", {24'd0, bus.o_scancode}, 32'h23);

    ps2d = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk) ps2c = 1'b0;
      @(negedge clk) ps2c = 1'b1;
      repeat (4) @(negedge clk);
    end
    ps2d = 1'b1;
    repeat (300) @(negedge clk);
    send(8'h1C);
    check("t6_before_rst", {28'd0, bus.o_direccion}, 32'h7);

    drive(8'h1B, 1'b0, 5);
    @(posedge clk);
    #3 rst = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0; m_dir = 4'b0000;
    exp_q.delete();
    #1;
    check("t6_rst_dir", {28'd0, bus.o_direccion}, 32'h0);
    check("t6_rst_code", {24'd0, bus.o_scancode}, 32'h0);
    check("t6_rst_flags", {28'd0, bus.o_key_valid, bus.o_frame_err, bus.o_extended, bus.o_break}, 32'h0);
    @(negedge clk);
    ps2c = 1'b1; ps2d = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    send(8'h1B);
    check("t6_after_rst", {28'd0, bus.o_direccion}, 32'h2);

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- System-clock-domain successor to the PS/2 keyboard front end.
- Oversamples iPS2CLK/iPS2D, assembles 11-bit frames, checks start/parity/stop, and tracks E0 (extended) and F0 (break) prefixes.
- Maintains held-key direction state (make sets a bit, break clears it).
- Feeds the game/control logic with o_direccion plus a per-key event strobe.

Parameters:
CLK_HZ, 50000000, system clock frequency; used to derive the timeout count.
FILTER_LEN, 8, consecutive identical samples needed to accept a new PS/2 clock level (range 2..31).
TIMEOUT_US, 1000, maximum gap between PS/2 falling edges inside a frame before the frame is aborted.
HOLD_MODE, 1, 1 = o_direccion bits set on make and cleared on break (multi-key); 0 = one-hot of the most recent make, cleared only by the break of that same key.
KEY_UP, 8'h1D, scan code for the up direction (W), bit 3.
KEY_RIGHT, 8'h23, scan code for the right direction (D), bit 2.
KEY_DOWN, 8'h1B, scan code for the down direction (S), bit 1.
KEY_LEFT, 8'h1C, scan code for the left direction (A), bit 0.

Ports:
Clock  in  1  system clock.
Reset  in  1  asynchronous, active-high reset.
iPS2CLK  in  1  raw PS/2 clock (asynchronous to Clock).
iPS2D  in  1  raw PS/2 data (asynchronous to Clock).
o_direccion  out  4  direction state {up, right, down, left}.
o_key_valid  out  1  one-cycle strobe: a complete key event has been decoded.
o_scancode  out  8  final scan code of the event; held until the next event.
o_extended  out  1  event was preceded by E0; held with o_scancode.
o_break  out  1  event was preceded by F0 (key release); held with o_scancode.
o_frame_err  out  1  one-cycle strobe on a parity, start, stop or timeout error.

Behaviour:
- Reset is asynchronous, active-high, and may be asserted at any time. Every output and state register clears to 0 and both FSMs return to IDLE. An in-progress frame is discarded; no partial event is emitted.
- Input conditioning:
  - Two-flop synchroniser on both iPS2CLK and iPS2D.
  - Filtered clock changes level only after FILTER_LEN consecutive equal synchronised samples.
  - A falling edge of the filtered clock produces a one-cycle sample strobe; the synchronised data bit is captured on that strobe.
- Frame FSM, states IDLE, SHIFT, CHECK:
  - IDLE: on a sample strobe with data 0 (start bit), set bitcount = 1 and go to SHIFT. A strobe with data 1 is ignored.
  - SHIFT: each strobe shifts data in LSB-first, frame = {d, frame[10:1]}, and increments bitcount. When bitcount reaches 11, go to CHECK.
  - CHECK (one cycle): the frame is valid iff frame[0] = 0, frame[10] = 1, and XOR of frame[9:1] = 1 (odd parity).
    - Valid: deliver byte frame[8:1] to the decoder FSM.
    - Invalid: pulse o_frame_err.
    - Either way, return to IDLE.
  - Timeout: a 32-bit counter, TO_CYC = CLK_HZ/1000000*TIMEOUT_US, clears on every strobe and counts only while in SHIFT. On reaching TO_CYC: pulse o_frame_err, go to IDLE, clear bitcount.
- Decoder FSM, flags ext and brk:
  - Byte E0: set ext.
  - Byte F0: set brk.
  - Any other byte: register o_scancode = byte, o_extended = ext, o_break = brk; pulse o_key_valid one cycle later than CHECK; clear both flags.
  - A frame error also clears both flags.
  - Total latency: o_key_valid asserts 2 Clock cycles after the filtered falling edge of the stop bit.
- Direction update, on o_key_valid with o_extended = 0 and the scan code matching one of the four KEY_* parameters:
  - HOLD_MODE=1: make sets the matching bit; break clears it. Any combination of bits may be set.
  - HOLD_MODE=0: make loads the one-hot pattern; break clears the output only if the one-hot matches the released key.
- Unmapped or extended codes produce an event but leave o_direccion unchanged.
- Typematic repeats (repeated makes) are idempotent.
- Simultaneous reset and strobe: reset wins.

Decomposition:
- Shared package ps2_pkg: constants PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0, frame length 11, default WASD codes, and the direction bit indices.
- One natural sub-module, ps2_rx_frame: synchroniser, filter, edge detect, frame FSM and timeout. It outputs a byte, a byte_valid strobe and frame_err.
- ps2_key_decoder instantiates ps2_rx_frame and implements the prefix/direction logic.

Test Plan:
1. Send frame 0x1C (odd parity) -> o_key_valid one cycle, o_scancode = 8'h1C, o_break = 0, o_direccion = 4'b0001.
2. Send 0x1D, then 0x23, then F0 1D -> o_direccion goes 4'b1000 -> 4'b1100 -> 4'b0100 (HOLD_MODE=1). Last event has o_break = 1, o_scancode = 8'h1D.
3. Send E0 75, then E0 F0 75 -> two events, both with o_extended = 1, the second with o_break = 1. o_direccion unchanged at 0.
4. Send 0x1B with the parity bit flipped -> o_frame_err pulses, no o_key_valid, o_direccion unchanged. A following good 0x1B -> o_direccion = 4'b0010.
5. Stop the clock after 5 bits for longer than TIMEOUT_US -> o_frame_err pulses and the FSM returns to IDLE. A following full 0x23 frame decodes correctly.
6. Assert Reset mid-frame after 0x1C is held, with 1-cycle glitches shorter than FILTER_LEN injected on iPS2CLK -> all outputs 0 immediately. The glitches produce no sample strobes.
